// File: rtl/m_control.sv
// m_control: sequencer for the M-extension multiply/divide unit.
// Accepts one MUL*/DIV*/REM* op at a time and steps the m_registers
// datapath through load, multiply or 32-step restoring divide, then
// flags completion with the result select and sign-fixup request.
module m_control #(
    parameter int unsigned MUL_LAT = 2  // DSP product latency after A/B registered, 1..7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] funct3,
    input  logic       rs1_sign,
    input  logic       rs2_sign,
    input  logic       rs2_zero,
    input  logic       sub_neg,
    input  logic       flush,
    output logic       ready,
    output logic       done,
    output logic       res_sel,
    output logic       res_neg,
    output logic [1:0] mux_A,
    output logic [1:0] mux_B,
    output logic [2:0] mux_R,
    output logic [1:0] mux_D,
    output logic [1:0] mux_Z
);

    // m_registers select encodings
    localparam logic [1:0] A_ZERO       = 2'd0;
    localparam logic [1:0] A_KEEP       = 2'd1;
    localparam logic [1:0] A_R_SIGNED   = 2'd2;
    localparam logic [1:0] A_R_UNSIGNED = 2'd3;
    localparam logic [1:0] B_ZERO       = 2'd0;
    localparam logic [1:0] B_KEEP       = 2'd1;
    localparam logic [1:0] B_D_SIGNED   = 2'd2;
    localparam logic [1:0] B_D_UNSIGNED = 2'd3;
    localparam logic [2:0] R_KEEP       = 3'd0;
    localparam logic [2:0] R_A          = 3'd1;
    localparam logic [2:0] R_A_NEG      = 3'd2;
    localparam logic [2:0] R_MULT_LOWER = 3'd3;
    localparam logic [2:0] R_SUB_KEEP   = 3'd4;
    localparam logic [1:0] D_KEEP       = 2'd0;
    localparam logic [1:0] D_B          = 2'd1;
    localparam logic [1:0] D_B_NEG      = 2'd2;
    localparam logic [1:0] D_SHR        = 2'd3;
    localparam logic [1:0] Z_KEEP       = 2'd0;
    localparam logic [1:0] Z_ZERO       = 2'd1;
    localparam logic [1:0] Z_MULT_UPPER = 2'd2;
    localparam logic [1:0] Z_SHL_ADD    = 2'd3;

    // Last MWAIT count value; only meaningful when MUL_LAT > 1
    localparam logic [4:0] MWAIT_LAST = 5'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MOPR, S_MWAIT, S_MCAP, S_DITER, S_DONE
    } state_t;

    state_t     state, state_next;
    logic [4:0] cnt, cnt_next;
    logic [2:0] op_f3;
    logic       op_s1, op_s2, op_z;
    logic       accept;

    logic       op_div, op_signed, op_b_signed;
    logic [1:0] a_sel, b_sel;

    // The subtractor borrow is consumed inside m_registers (SUB_KEEP / SHL_ADD)
    logic       unused;
    assign unused = sub_neg;

    assign op_div      = op_f3[2];
    assign op_signed   = op_div ? !op_f3[0] : (op_f3 != 3'b011);
    assign op_b_signed = !op_f3[2] && !op_f3[1];
    assign a_sel       = op_signed ? A_R_SIGNED : A_R_UNSIGNED;
    assign b_sel       = op_b_signed ? B_D_SIGNED : B_D_UNSIGNED;
    assign accept      = start && ready && !flush;

    // State, counter and latched-operation registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_f3 <= '0;
            op_s1 <= 1'b0;
            op_s2 <= 1'b0;
            op_z  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_f3 <= funct3;
                op_s1 <= rs1_sign;
                op_s2 <= rs2_sign;
                op_z  <= rs2_zero;
            end
        end
    end

    // Next-state, counter and datapath select decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mux_A      = A_ZERO;
        mux_B      = B_ZERO;
        mux_R      = R_KEEP;
        mux_D      = D_KEEP;
        mux_Z      = Z_KEEP;
        ready      = (state == S_IDLE);
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (op_div) begin
                    mux_R      = (op_signed && op_s1) ? R_A_NEG : R_A;
                    mux_D      = (op_signed && op_s2) ? D_B_NEG : D_B;
                    mux_Z      = Z_ZERO;
                    cnt_next   = '0;
                    state_next = S_DITER;
                end else begin
                    mux_R      = R_A;
                    mux_D      = D_B;
                    state_next = S_MOPR;
                end
            end
            S_MOPR: begin
                mux_A      = a_sel;
                mux_B      = b_sel;
                cnt_next   = '0;
                state_next = (MUL_LAT > 1) ? S_MWAIT : S_MCAP;
            end
            S_MWAIT: begin
                mux_A = A_KEEP;
                mux_B = B_KEEP;
                if (cnt == MWAIT_LAST) state_next = S_MCAP;
                else                   cnt_next   = cnt + 5'd1;
            end
            S_MCAP: begin
                // A/B reload the same operands so MULT_UPPER sees its sign mode
                mux_A      = a_sel;
                mux_B      = b_sel;
                mux_R      = R_MULT_LOWER;
                mux_Z      = Z_MULT_UPPER;
                state_next = S_DONE;
            end
            S_DITER: begin
                mux_R = R_SUB_KEEP;
                mux_Z = Z_SHL_ADD;
                mux_D = D_SHR;
                if (cnt == 5'd31) state_next = S_DONE;
                else              cnt_next   = cnt + 5'd1;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            done       = 1'b0;
            mux_A      = A_ZERO;
            mux_B      = B_ZERO;
            mux_R      = R_KEEP;
            mux_D      = D_KEEP;
            mux_Z      = Z_KEEP;
        end
    end

    // Result select and sign fixup, presented only alongside done
    always_comb begin
        res_sel = 1'b0;
        res_neg = 1'b0;
        if (done) begin
            res_sel = (op_f3 == 3'b000) || (op_f3 == 3'b110) || (op_f3 == 3'b111);
            res_neg = ((op_f3 == 3'b100) && (op_s1 ^ op_s2) && !op_z)
                   || ((op_f3 == 3'b110) && op_s1);
        end
    end

endmodule

// File: tb/tb_m_control.sv
// tb_m_control: drives m_control with a behavioural m_registers model and
// compares completed results against plain RISC-V M arithmetic.
module tb_m_control;

    localparam int unsigned MUL_LAT = 2;

    localparam logic [1:0] A_ZERO = 2'd0, A_KEEP = 2'd1, A_RS = 2'd2, A_RU = 2'd3;
    localparam logic [1:0] B_ZERO = 2'd0, B_KEEP = 2'd1, B_DS = 2'd2, B_DU = 2'd3;
    localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_ANEG = 3'd2, R_ML = 3'd3, R_SK = 3'd4;
    localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_BNEG = 2'd2, D_SHR = 2'd3;
    localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_MU = 2'd2, Z_SA = 2'd3;

    logic       clk = 1'b0;
    logic       resetn, start, rs1_sign, rs2_sign, rs2_zero, sub_neg, flush;
    logic [2:0] funct3;
    logic       ready, done, res_sel, res_neg;
    logic [1:0] mux_A, mux_B, mux_D, mux_Z;
    logic [2:0] mux_R;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    m_control #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero),
        .sub_neg(sub_neg), .flush(flush), .ready(ready), .done(done),
        .res_sel(res_sel), .res_neg(res_neg), .mux_A(mux_A), .mux_B(mux_B),
        .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z)
    );

    // Behavioural datapath: R/D are 64-bit so the divisor can start at b<<31
    logic [31:0]        op_a = '0, op_b = '0;
    logic [31:0]        neg_a, neg_b;
    logic signed [32:0] ra = '0, rb = '0;
    logic [63:0]        rr = '0, rd = '0;
    logic [31:0]        rz = '0;
    logic signed [65:0] prod;

    assign neg_a   = -op_a;
    assign neg_b   = -op_b;
    assign prod    = ra * rb;
    assign sub_neg = (rr < rd);

    always @(posedge clk) begin
        case (mux_A)
            A_ZERO: ra <= '0;
            A_RS:   ra <= {rr[31], rr[31:0]};
            A_RU:   ra <= {1'b0, rr[31:0]};
            default: ;
        endcase
        case (mux_B)
            B_ZERO: rb <= '0;
            B_DS:   rb <= {rd[62], rd[62:31]};
            B_DU:   rb <= {1'b0, rd[62:31]};
            default: ;
        endcase
        case (mux_R)
            R_A:    rr <= {32'b0, op_a};
            R_ANEG: rr <= {32'b0, neg_a};
            R_ML:   rr <= {32'b0, prod[31:0]};
            R_SK:   if (!sub_neg) rr <= rr - rd;
            default: ;
        endcase
        case (mux_D)
            D_B:    rd <= {1'b0, op_b, 31'b0};
            D_BNEG: rd <= {1'b0, neg_b, 31'b0};
            D_SHR:  rd <= rd >> 1;
            default: ;
        endcase
        case (mux_Z)
            Z_ZERO: rz <= '0;
            Z_MU:   rz <= prod[63:32];
            Z_SA:   rz <= {rz[30:0], ~sub_neg};
            default: ;
        endcase
    end

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic exp_sel(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic exp_neg(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 == 3'd4) return (a[31] ^ b[31]) && (b != 0);
        if (f3 == 3'd6) return a[31];
        return 1'b0;
    endfunction

    // Issues one op and waits for done; reports latency, fixed-up result and raw R/Z
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [31:0] res, output logic rsel,
                          output logic rneg, output logic [31:0] zv, output logic [31:0] rv,
                          output logic tout);
        int w;
        cyc = 0; res = '0; rsel = 1'b0; rneg = 1'b0; zv = '0; rv = '0; tout = 1'b0; w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin @(negedge clk); w++; end
        if (!ready) begin tout = 1'b1; return; end
        start = 1'b1; funct3 = f3; rs1_sign = a[31]; rs2_sign = b[31]; rs2_zero = (b == 0);
        op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        if (!done) begin tout = 1'b1; return; end
        rsel = res_sel; rneg = res_neg; zv = rz; rv = rr[31:0];
        res = rsel ? rv : zv;
        if (rneg) res = -res;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_total++; if ({res_sel, res_neg} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {res_sel, res_neg}); else n_pass++;
        n_total++;
        if ({mux_A, mux_B, mux_R, mux_D, mux_Z} !== {A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP})
            $display("FAIL reset_mux: got %h expected %h", {mux_A, mux_B, mux_R, mux_D, mux_Z},
                     {A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  tf3 [12] = '{3, 1, 0, 2, 4, 6, 5, 4, 6, 4, 6, 7};
        logic [31:0] ta  [12] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'd100};
        logic [31:0] tb  [12] = '{32'hFFFFFFFF, 32'd3, 32'd3, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
        int cyc; logic [31:0] res, zv, rv; logic rsel, rneg, tout;
        for (int i = 0; i < 12; i++) begin
            run_op(tf3[i], ta[i], tb[i], cyc, res, rsel, rneg, zv, rv, tout);
            n_total++;
            if (tout) $display("FAIL dir%0d_timeout: no done within bound", i); else n_pass++;
            n_total++;
            if (cyc != (tf3[i][2] ? 34 : 3 + int'(MUL_LAT)))
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, tf3[i][2] ? 34 : 3 + int'(MUL_LAT));
            else n_pass++;
            n_total++;
            if (rsel !== exp_sel(tf3[i])) $display("FAIL dir%0d_res_sel: got %b expected %b", i, rsel, exp_sel(tf3[i])); else n_pass++;
            n_total++;
            if (rneg !== exp_neg(tf3[i], ta[i], tb[i])) $display("FAIL dir%0d_res_neg: got %b expected %b", i, rneg, exp_neg(tf3[i], ta[i], tb[i])); else n_pass++;
            n_total++;
            if (res !== ref_result(tf3[i], ta[i], tb[i])) $display("FAIL dir%0d_result: got %h expected %h", i, res, ref_result(tf3[i], ta[i], tb[i])); else n_pass++;
            if (i == 0) begin
                n_total++;
                if ({zv, rv} !== {32'hFFFFFFFE, 32'h1}) $display("FAIL mulhu_raw_ZR: got %h expected %h", {zv, rv}, {32'hFFFFFFFE, 32'h1}); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        int cyc; logic [31:0] a, b, res, zv, rv; logic [2:0] f3; logic rsel, rneg, tout;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            run_op(f3, a, b, cyc, res, rsel, rneg, zv, rv, tout);
            if (tout || cyc != (f3[2] ? 34 : 3 + int'(MUL_LAT)) || rsel !== exp_sel(f3)
                || rneg !== exp_neg(f3, a, b) || res !== ref_result(f3, a, b)) begin
                $display("FAIL rand%0d f3=%0d a=%h b=%h: got res=%h lat=%0d sel=%b neg=%b expected res=%h",
                         i, f3, a, b, res, cyc, rsel, rneg, ref_result(f3, a, b));
                bad++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL random_ops: got %0d bad ops expected 0", bad); else n_pass++;
    endtask

    task automatic test_flush();
        int cyc, w, seen; logic [31:0] res, zv, rv; logic rsel, rneg, tout;
        seen = 0; w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin @(negedge clk); w++; end
        start = 1'b1; funct3 = 3'd4; op_a = 32'hFFFFFFF9; op_b = 32'd2;
        rs1_sign = 1'b1; rs2_sign = 1'b0; rs2_zero = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 11) begin
            if (done) seen++;
            @(negedge clk); cyc++;
        end
        flush = 1'b1;
        #1;
        n_total++;
        if ({done, mux_R, mux_D, mux_Z} !== {1'b0, R_KEEP, D_KEEP, Z_KEEP})
            $display("FAIL flush_cycle_outputs: got %h expected %h", {done, mux_R, mux_D, mux_Z}, {1'b0, R_KEEP, D_KEEP, Z_KEEP});
        else n_pass++;
        @(negedge clk);
        flush = 1'b0;
        n_total++;
        if (ready !== 1'b1) $display("FAIL flush_ready: got %b expected 1", ready); else n_pass++;
        repeat (40) begin if (done) seen++; @(negedge clk); end
        n_total++;
        if (seen != 0) $display("FAIL flush_no_done: got %0d done pulses expected 0", seen); else n_pass++;
        run_op(3'd5, 32'd100, 32'd7, cyc, res, rsel, rneg, zv, rv, tout);
        n_total++;
        if (tout || {zv, rv} !== {32'd14, 32'd2})
            $display("FAIL flush_then_divu: got Z=%h R=%h expected Z=0000000e R=00000002", zv, rv);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_ready, n_done, n_both, bad, w;
        n_ready = 0; n_done = 0; n_both = 0; bad = 0; w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin @(negedge clk); w++; end
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ready) n_ready++;
            if (done) begin
                n_done++;
                if (rr[31:0] !== 32'd15 || res_sel !== 1'b1) bad++;
            end
            if (ready && done) n_both++;
            @(negedge clk);
        end
        start = 1'b0;
        n_total++; if (n_ready != 10) $display("FAIL b2b_accepts: got %0d ready cycles expected 10", n_ready); else n_pass++;
        n_total++; if (n_done != 10) $display("FAIL b2b_dones: got %0d expected 10", n_done); else n_pass++;
        n_total++; if (n_both != 0) $display("FAIL b2b_ready_in_done: got %0d expected 0", n_both); else n_pass++;
        n_total++; if (bad != 0) $display("FAIL b2b_results: got %0d bad expected 0", bad); else n_pass++;
        w = 0;
        while (!ready && w < 20) begin @(negedge clk); w++; end
    endtask

    task automatic test_mid_reset();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_total++;
        if ({ready, done, mux_R, mux_Z} !== {1'b1, 1'b0, R_KEEP, Z_KEEP})
            $display("FAIL midreset_state: got %h expected %h", {ready, done, mux_R, mux_Z}, {1'b1, 1'b0, R_KEEP, Z_KEEP});
        else n_pass++;
        repeat (40) begin if (done) seen++; @(negedge clk); end
        n_total++;
        if (seen != 0) $display("FAIL midreset_no_done: got %0d expected 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
